// File: rtl/spi_bus_arbiter_pkg.sv
// Shared state encodings and default timing constants for the SPI bus arbiter.
package spi_arb_defines;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int unsigned DefGapCycles = 4;
  localparam int unsigned DefTimeout   = 4096;

endpackage

// File: rtl/spi_bus_arbiter_rr_priority_picker.sv
// Round-robin picker: one-hot select of the first requester at index >= ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    sel_o,
  output logic            valid_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   sel_rot;
  logic [2*N-1:0] sel_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_i;
    req_rot = req_dbl[N-1:0];
    sel_rot = req_rot & (-req_rot);
    sel_dbl = {sel_rot, sel_rot} << ptr_i;
    sel_o   = sel_dbl[2*N-1:N];
    valid_o = |req_i;
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between N masters: round-robin grant, CS-high gap, grant watchdog.
module spi_bus_arbiter
  import spi_arb_defines::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned GAP_CYCLES = DefGapCycles,
  parameter int unsigned TIMEOUT    = DefTimeout,
  parameter logic        SCLK_IDLE  = 1'b0
) (
  input  logic         cclk,
  input  logic         rstb,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] done_i,
  output logic [N-1:0] gnt_o,
  output logic [N-1:0] timeout_err_o,
  input  logic [N-1:0] m_sclk_i,
  input  logic [N-1:0] m_dout_i,
  input  logic [N-1:0] m_csb_i,
  output logic [N-1:0] m_din_o,
  output logic         spi_sclk_o,
  output logic         spi_dout_o,
  input  logic         spi_din_i,
  output logic [N-1:0] spi_csb_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned WdW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);
  localparam logic [WdW-1:0]  WdMax   = '1;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    terr_q, terr_d;
  logic [N-1:0]    csb_q, csb_d;
  logic [N-1:0]    din_q, din_d;
  logic            sclk_q, sclk_d;
  logic            dout_q, dout_d;

  logic [N-1:0]    pick_sel;
  logic            pick_valid;
  logic [PtrW-1:0] owner;
  logic            rel_own;
  logic            wd_hit;
  logic            mux_en;

  rr_priority_picker #(
    .N (N)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .sel_o   (pick_sel),
    .valid_o (pick_valid)
  );

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) owner = PtrW'(i);
    end
    // Only the owner's done/req matter; a clean release wins over a coincident timeout.
    rel_own = (|(done_i & gnt_q)) || !(|(req_i & gnt_q));
    wd_hit  = (TIMEOUT != 0) && (wd_q == WdLast);
    mux_en  = (state_q == S_OWN) && !rel_own && !wd_hit;

    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    gnt_d   = gnt_q;
    terr_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_sel;
          wd_d    = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        wd_d = (wd_q == WdMax) ? wd_q : wd_q + WdW'(1);
        if (rel_own || wd_hit) begin
          gnt_d   = '0;
          ptr_d   = (owner == PtrW'(N - 1)) ? '0 : owner + PtrW'(1);
          gap_d   = '0;
          state_d = S_GAP;
          if (!rel_own) terr_d = gnt_q;
        end
      end
      S_GAP: begin
        if (gap_q == GapLast) state_d = S_IDLE;
        else                  gap_d   = gap_q + GapW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    sclk_d = mux_en ? |(m_sclk_i & gnt_q) : SCLK_IDLE;
    dout_d = mux_en ? |(m_dout_i & gnt_q) : 1'b0;
    csb_d  = mux_en ? (m_csb_i | ~gnt_q) : '1;
    din_d  = mux_en ? (gnt_q & {N{spi_din_i}}) : '0;
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      terr_q  <= '0;
      csb_q   <= '1;
      din_q   <= '0;
      sclk_q  <= SCLK_IDLE;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      gnt_q   <= gnt_d;
      terr_q  <= terr_d;
      csb_q   <= csb_d;
      din_q   <= din_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign timeout_err_o = terr_q;
  assign spi_csb_o     = csb_q;
  assign m_din_o       = din_q;
  assign spi_sclk_o    = sclk_q;
  assign spi_dout_o    = dout_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter (N=2, GAP=4, TIMEOUT=16): grant/timeout event scoreboard plus pin checks.
module tb_spi_bus_arbiter;

  logic       cclk;
  logic       rstb;
  logic [1:0] req, done, gnt, terr, m_sclk, m_dout, m_csb, m_din, spi_csb;
  logic       spi_sclk, spi_dout, spi_din;

  logic [3:0] pk_req, pk_sel;
  logic [1:0] pk_ptr;
  logic       pk_valid;

  typedef struct {
    logic [1:0] gnt;
    logic [1:0] terr;
    int         at;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [1:0] gnt_prev = 2'b00;
  int   c0, d0, e0, f0;

  spi_bus_arbiter #(
    .N          (2),
    .GAP_CYCLES (4),
    .TIMEOUT    (16),
    .SCLK_IDLE  (1'b0)
  ) dut (
    .cclk          (cclk),
    .rstb          (rstb),
    .req_i         (req),
    .done_i        (done),
    .gnt_o         (gnt),
    .timeout_err_o (terr),
    .m_sclk_i      (m_sclk),
    .m_dout_i      (m_dout),
    .m_csb_i       (m_csb),
    .m_din_o       (m_din),
    .spi_sclk_o    (spi_sclk),
    .spi_dout_o    (spi_dout),
    .spi_din_i     (spi_din),
    .spi_csb_o     (spi_csb)
  );

  rr_priority_picker #(
    .N (4)
  ) u_pick (
    .req_i   (pk_req),
    .ptr_i   (pk_ptr),
    .sel_o   (pk_sel),
    .valid_o (pk_valid)
  );

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  initial forever begin
    @(posedge cclk);
    cyc++;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: cycle %0d got %0h, required %0h", name, cyc, act, exp);
  endtask

  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge cclk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [1:0] t, input int at);
    ev_t x;
    x.gnt  = g;
    x.terr = t;
    x.at   = at;
    exp_q.push_back(x);
  endtask

  // Monitor: every gnt change or timeout pulse is an event checked against the queue.
  initial forever begin
    @(negedge cclk);
    if (gnt !== gnt_prev || terr !== 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: cycle %0d gnt=%b terr=%b, required no event",
                 cyc, gnt, terr);
      end else begin
        e = exp_q.pop_front();
        if (gnt === e.gnt && terr === e.terr && cyc == e.at) n_pass++;
        else $display("FAIL grant_event: cycle %0d gnt=%b terr=%b, required cycle %0d gnt=%b terr=%b",
                      cyc, gnt, terr, e.at, e.gnt, e.terr);
      end
    end
    gnt_prev = gnt;
  end

  initial begin
    rstb = 1'b0; req = '0; done = '0; m_sclk = '0; m_dout = '0; m_csb = '1; spi_din = 1'b0;

    // Standalone picker vectors (N=4)
    pk_req = 4'b0000; pk_ptr = 2'd1; #1;
    chk("pick_none_valid", {7'd0, pk_valid}, 8'd0);
    chk("pick_none_sel", {4'd0, pk_sel}, 8'h0);
    pk_req = 4'b1010; pk_ptr = 2'd0; #1;
    chk("pick_1010_p0", {4'd0, pk_sel}, 8'h2);
    chk("pick_1010_p0_valid", {7'd0, pk_valid}, 8'd1);
    pk_req = 4'b1010; pk_ptr = 2'd2; #1;
    chk("pick_1010_p2", {4'd0, pk_sel}, 8'h8);
    pk_req = 4'b0011; pk_ptr = 2'd3; #1;
    chk("pick_0011_p3_wrap", {4'd0, pk_sel}, 8'h1);
    pk_req = 4'b1000; pk_ptr = 2'd3; #1;
    chk("pick_1000_p3", {4'd0, pk_sel}, 8'h8);

    // Reset state
    go(2);
    chk("rst_gnt", {6'd0, gnt}, 8'h0);
    chk("rst_terr", {6'd0, terr}, 8'h0);
    chk("rst_csb", {6'd0, spi_csb}, 8'h3);
    chk("rst_sclk", {7'd0, spi_sclk}, 8'h0);
    chk("rst_dout", {7'd0, spi_dout}, 8'h0);
    chk("rst_mdin", {6'd0, m_din}, 8'h0);

    // Single requester, pin mux and isolation
    rstb = 1'b1; c0 = cyc;
    m_csb = 2'b10; req = 2'b01;
    push(2'b01, 2'b00, c0 + 1);
    push(2'b00, 2'b00, c0 + 11);
    go(c0 + 1); chk("single_csb_pre", {6'd0, spi_csb}, 8'h3);
    go(c0 + 2); chk("single_csb_low", {6'd0, spi_csb}, 8'h2);
    go(c0 + 3); m_sclk = 2'b10; m_dout = 2'b10; m_csb = 2'b00; spi_din = 1'b1;
    go(c0 + 4);
    chk("iso_sclk", {7'd0, spi_sclk}, 8'h0);
    chk("iso_dout", {7'd0, spi_dout}, 8'h0);
    chk("iso_csb", {6'd0, spi_csb}, 8'h2);
    chk("iso_mdin", {6'd0, m_din}, 8'h1);
    m_sclk = 2'b01; m_dout = 2'b01; m_csb = 2'b10;
    go(c0 + 5);
    chk("own_sclk", {7'd0, spi_sclk}, 8'h1);
    chk("own_dout", {7'd0, spi_dout}, 8'h1);
    m_sclk = '0; m_dout = '0; spi_din = 1'b0;
    go(c0 + 10); done = 2'b01; req = 2'b00;
    go(c0 + 11); done = 2'b00; m_csb = 2'b11;
    for (int k = 0; k < 4; k++) begin
      go(c0 + 11 + k);
      chk("gap_csb_high", {6'd0, spi_csb}, 8'h3);
      chk("gap_sclk_idle", {7'd0, spi_sclk}, 8'h0);
    end

    // Simultaneous requests from reset: alternation over 4 grants
    go(c0 + 18); rstb = 1'b0;
    go(c0 + 20); rstb = 1'b1; d0 = cyc;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push((k % 2 == 1) ? 2'b10 : 2'b01, 2'b00, d0 + 1 + 10 * k);
      push(2'b00, 2'b00, d0 + 6 + 10 * k);
    end
    for (int k = 0; k < 4; k++) begin
      go(d0 + 5 + 10 * k);
      done = (k % 2 == 1) ? 2'b10 : 2'b01;
      if (k == 3) req = 2'b00;
      go(d0 + 6 + 10 * k);
      done = 2'b00;
    end

    // Watchdog on requester 1, then done coincident with the timeout cycle
    go(d0 + 42); e0 = cyc;
    req = 2'b10;
    push(2'b10, 2'b00, e0 + 1);
    push(2'b00, 2'b10, e0 + 17);
    push(2'b01, 2'b00, e0 + 22);
    push(2'b00, 2'b00, e0 + 26);
    push(2'b10, 2'b00, e0 + 31);
    push(2'b00, 2'b00, e0 + 47);
    go(e0 + 5);  req = 2'b11;
    go(e0 + 17); chk("wd_csb_high", {6'd0, spi_csb}, 8'h3);
    go(e0 + 25); done = 2'b01; req = 2'b10;
    go(e0 + 26); done = 2'b00;
    go(e0 + 46); done = 2'b10; req = 2'b00;
    go(e0 + 47); done = 2'b00;

    // Reset mid-transfer with requester 1 owning
    go(e0 + 55); f0 = cyc;
    req = 2'b10; m_csb = 2'b00; m_sclk = 2'b11;
    push(2'b10, 2'b00, f0 + 1);
    push(2'b00, 2'b00, f0 + 4);
    push(2'b01, 2'b00, f0 + 5);
    push(2'b00, 2'b00, f0 + 9);
    go(f0 + 2); spi_din = 1'b1;
    go(f0 + 3);
    chk("rst_mid_csb_pre", {6'd0, spi_csb}, 8'h1);
    chk("rst_mid_sclk_pre", {7'd0, spi_sclk}, 8'h1);
    chk("rst_mid_mdin_pre", {6'd0, m_din}, 8'h2);
    rstb = 1'b0;
    go(f0 + 4);
    chk("rst_mid_csb", {6'd0, spi_csb}, 8'h3);
    chk("rst_mid_sclk", {7'd0, spi_sclk}, 8'h0);
    chk("rst_mid_mdin", {6'd0, m_din}, 8'h0);
    rstb = 1'b1; req = 2'b11; m_csb = 2'b11; m_sclk = 2'b00; spi_din = 1'b0;
    go(f0 + 8); done = 2'b01; req = 2'b00;
    go(f0 + 9); done = 2'b00;

    go(f0 + 16);
    chk("events_outstanding", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
